// File: rtl/serial_parallel_if.sv
// Serial receiver bus: serial line and length control in, received word and status out.
// master drives the serial side and ack; slave is the receiver.
interface serial_parallel_if #(
  parameter int PARALLEL_PORT_WIDTH = 15,
  parameter int BIT_LENGTH          = 4
);
  logic                           din;
  logic [BIT_LENGTH-1:0]          bit_length;
  logic                           ack_in;
  logic [PARALLEL_PORT_WIDTH-1:0] dout;
  logic                           dv_out;
  logic                           busy;
  logic                           overrun;

  modport master (
    output din, bit_length, ack_in,
    input  dout, dv_out, busy, overrun
  );

  modport slave (
    input  din, bit_length, ack_in,
    output dout, dv_out, busy, overrun
  );
endinterface

// File: rtl/serial_parallel.sv
// Serial-to-parallel receiver: start bit (0) then bit_length data bits MSB first,
// one bit per clock, no stop bit. Word is right-aligned in dout with a dv/ack handshake.
module serial_parallel #(
  parameter int PARALLEL_PORT_WIDTH = 15,
  parameter int BIT_LENGTH          = 4
) (
  input  logic               clk,
  input  logic               rst,
  serial_parallel_if.slave   bus
);

  typedef enum logic {IDLE, RECEIVE} state_t;

  state_t                         state;
  logic [BIT_LENGTH-1:0]          counter;
  logic [PARALLEL_PORT_WIDTH-1:0] shift_reg;
  logic [PARALLEL_PORT_WIDTH-1:0] shifted;

  // The completing word includes the bit on din this cycle, so dout is loaded from here.
  always_comb begin
    shifted = {shift_reg[PARALLEL_PORT_WIDTH-2:0], bus.din};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      counter     <= '0;
      shift_reg   <= '0;
      bus.dout    <= '0;
      bus.dv_out  <= 1'b0;
      bus.busy    <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.overrun <= 1'b0;
      if (bus.ack_in) begin
        bus.dv_out <= 1'b0;
      end

      case (state)
        IDLE: begin
          // X/Z on din compare false here, so only a clean 0 starts a frame.
          if (bus.din == 1'b0 && bus.bit_length != '0) begin
            state     <= RECEIVE;
            counter   <= bus.bit_length - BIT_LENGTH'(1);
            shift_reg <= '0;
            bus.busy  <= 1'b1;
          end
        end

        RECEIVE: begin
          shift_reg <= shifted;
          counter   <= counter - BIT_LENGTH'(1);
          if (counter == '0) begin
            // A completing word wins over a same-cycle ack; overrun flags a lost word.
            bus.dout    <= shifted;
            bus.dv_out  <= 1'b1;
            bus.overrun <= bus.dv_out & ~bus.ack_in;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_parallel.sv
// Bench for serial_parallel: directed vector table, hand sequences for reset and
// zero-length corner cases, then random frames checked against a word-level model.
module tb_serial_parallel;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_parallel_if #(.PARALLEL_PORT_WIDTH(15), .BIT_LENGTH(4)) sp ();
  serial_parallel_if #(.PARALLEL_PORT_WIDTH(8),  .BIT_LENGTH(4)) sn ();

  assign sn.din        = sp.din;
  assign sn.bit_length = sp.bit_length;
  assign sn.ack_in     = sp.ack_in;

  serial_parallel #(.PARALLEL_PORT_WIDTH(15), .BIT_LENGTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sp.slave)
  );

  serial_parallel #(.PARALLEL_PORT_WIDTH(8), .BIT_LENGTH(4)) dut_narrow (
    .clk (clk),
    .rst (rst),
    .bus (sn.slave)
  );

  typedef struct {
    int          len;
    int          len_after;
    logic [15:0] data;
    logic        ack_last;
    int          gap;
    logic        gap_ack;
    logic [15:0] exp_dout;
    logic        exp_ov;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered just after a negedge; returns just after the negedge following the last bit.
  task automatic send_frame(input int len, input int len_after, input logic [15:0] data,
                            input logic ack_last, output int busy_cnt);
    busy_cnt      = 0;
    sp.din        = 1'b0;
    sp.bit_length = 4'(len);
    sp.ack_in     = 1'b0;
    @(negedge clk);
    sp.bit_length = 4'(len_after);
    for (int i = len - 1; i >= 0; i--) begin
      if (sp.busy) busy_cnt++;
      sp.din    = data[i];
      sp.ack_in = (i == 0) ? ack_last : 1'b0;
      @(negedge clk);
    end
    sp.din    = 1'b1;
    sp.ack_in = 1'b0;
  endtask

  task automatic check_done(input string tag, input int len, input int busy_cnt,
                            input logic [15:0] exp, input logic exp_ov);
    check({tag, "_dout"},   32'(sp.dout), 32'(exp[14:0]));
    check({tag, "_narrow"}, 32'(sn.dout), 32'(exp[7:0]));
    check({tag, "_dv"},     32'(sp.dv_out), 32'd1);
    check({tag, "_ovr"},    32'(sp.overrun), 32'(exp_ov));
    check({tag, "_busy"},   32'(busy_cnt), 32'(len));
    check({tag, "_idle"},   32'(sp.busy), 32'd0);
  endtask

  task automatic idle(input int n, input logic ack_first);
    for (int k = 0; k < n; k++) begin
      sp.din    = 1'b1;
      sp.ack_in = (k == 0) ? ack_first : 1'b0;
      @(negedge clk);
    end
    sp.ack_in = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          bc;
    logic        pending;
    int          len;
    int          gap;
    logic [15:0] data;
    logic        ackl;
    logic        gack;
    logic        exp_ov;

    vecs[0] = '{4,  4, 16'h000B, 1'b0, 2, 1'b1, 16'h000B, 1'b0};
    vecs[1] = '{15, 15, 16'h5A5A, 1'b0, 1, 1'b1, 16'h5A5A, 1'b0};
    vecs[2] = '{4,  8, 16'h000A, 1'b0, 0, 1'b0, 16'h000A, 1'b0};
    vecs[3] = '{4,  4, 16'h0003, 1'b0, 0, 1'b0, 16'h0003, 1'b1};
    vecs[4] = '{4,  4, 16'h0005, 1'b1, 3, 1'b0, 16'h0005, 1'b0};
    vecs[5] = '{1,  1, 16'h0001, 1'b0, 2, 1'b1, 16'h0001, 1'b1};
    vecs[6] = '{8,  8, 16'h00C3, 1'b0, 1, 1'b1, 16'h00C3, 1'b0};
    vecs[7] = '{12, 12, 16'h0FFF, 1'b0, 2, 1'b1, 16'h0FFF, 1'b0};

    sp.din        = 1'b1;
    sp.bit_length = 4'd4;
    sp.ack_in     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dout", 32'(sp.dout), 32'd0);
    check("rst_dv",   32'(sp.dv_out), 32'd0);
    check("rst_busy", 32'(sp.busy), 32'd0);
    check("rst_ovr",  32'(sp.overrun), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].len, vecs[v].len_after, vecs[v].data, vecs[v].ack_last, bc);
      check_done($sformatf("vec%0d", v), vecs[v].len, bc, vecs[v].exp_dout, vecs[v].exp_ov);
      if (vecs[v].gap > 0) begin
        idle(1, vecs[v].gap_ack);
        check($sformatf("vec%0d_ovr_pulse", v), 32'(sp.overrun), 32'd0);
        check($sformatf("vec%0d_dv_ack", v), 32'(sp.dv_out), 32'(!vecs[v].gap_ack));
        idle(vecs[v].gap - 1, 1'b0);
      end
    end

    // Zero-length frame request: start bits ignored, stays idle.
    sp.bit_length = 4'd0;
    sp.din        = 1'b0;
    repeat (3) @(negedge clk);
    check("zero_len_busy", 32'(sp.busy), 32'd0);
    check("zero_len_dv",   32'(sp.dv_out), 32'd0);
    idle(1, 1'b0);
    check("zero_len_busy2", 32'(sp.busy), 32'd0);

    // Leave a word pending, then abort a frame with an async reset after two bits.
    send_frame(4, 4, 16'h0009, 1'b0, bc);
    check_done("pre_abort", 4, bc, 16'h0009, 1'b0);
    sp.din = 1'b0; sp.bit_length = 4'd4;
    @(negedge clk);
    sp.din = 1'b1;
    @(negedge clk);
    sp.din = 1'b0;
    @(negedge clk);
    check("abort_busy_before", 32'(sp.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_dout", 32'(sp.dout), 32'd0);
    check("abort_dv",   32'(sp.dv_out), 32'd0);
    check("abort_busy", 32'(sp.busy), 32'd0);
    check("abort_ovr",  32'(sp.overrun), 32'd0);
    sp.din = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_frame(4, 4, 16'h0006, 1'b0, bc);
    check_done("post_abort", 4, bc, 16'h0006, 1'b0);
    idle(1, 1'b1);

    // Random loopback: word-level model tracks only whether a word is still unacknowledged.
    pending = 1'b0;
    for (int f = 0; f < 100; f++) begin
      len    = int'($urandom_range(1, 15));
      data   = 16'($urandom) & 16'((32'd1 << len) - 1);
      ackl   = 1'($urandom_range(0, 3) == 0);
      gap    = int'($urandom_range(0, 3));
      gack   = 1'($urandom_range(0, 1));
      exp_ov = pending && !ackl;
      send_frame(len, int'($urandom_range(0, 15)), data, ackl, bc);
      check_done($sformatf("rnd%0d", f), len, bc, data, exp_ov);
      pending = 1'b1;
      if (gap > 0) begin
        idle(gap, gack);
        if (gack) pending = 1'b0;
        check($sformatf("rnd%0d_dv_gap", f), 32'(sp.dv_out), 32'(pending));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/serial_parallel.md
SERIAL_PARALLEL -- requirements
Module: serial_parallel

Interface
REQ-001 The block SHALL have parameter PARALLEL_PORT_WIDTH, default 15: width of the parallel output word.
REQ-002 The block SHALL have parameter BIT_LENGTH, default 4: width of the bit_length input and of the internal bit counter.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port din, input, 1: serial line; idles high (pulled up, or 1/Z/X); a logic 0 is a start bit.
REQ-006 Port bit_length, input, BIT_LENGTH: number of data bits per frame, sampled only at start-bit detection.
REQ-007 Port ack_in, input, 1: consumer acknowledge; clears dv_out.
REQ-008 Port dout, output, PARALLEL_PORT_WIDTH: last received word, right-aligned, upper bits zero.
REQ-009 Port dv_out, output, 1: level; high while dout holds an unacknowledged word.
REQ-010 Port busy, output, 1: high while in RECEIVE.
REQ-011 Port overrun, output, 1: one-cycle pulse when a new word overwrites an unacknowledged word.

Function
REQ-012 Frame format SHALL be: one start bit (0), then bit_length data bits, MSB first (bit bit_length-1 first, bit 0 last), one bit per clk cycle, with no stop bit.
REQ-013 The FSM SHALL have two states: IDLE and RECEIVE.
REQ-014 IDLE: if din is logic 0 at a clk edge and bit_length != 0, the block SHALL go to RECEIVE, latch len = bit_length, set counter = bit_length-1, and clear the shift register.
REQ-015 IDLE: a start bit seen while bit_length == 0 SHALL be ignored; the block stays in IDLE and dv_out is unchanged.
REQ-016 In IDLE, any din value other than logic 0 (1, Z, X) SHALL be treated as idle.
REQ-017 RECEIVE, each cycle: shift_reg <= {shift_reg[W-2:0], din}; counter decrements by 1.
REQ-018 RECEIVE with counter == 0: dout <= the shifted value including the current din; dv_out <= 1; return to IDLE.
REQ-019 Latency: dout/dv_out SHALL update at the edge that samples the last data bit, i.e. visible the cycle after the last bit is on din.
REQ-020 Changes to bit_length during RECEIVE SHALL have no effect; the latched len governs the frame.
REQ-021 If len > PARALLEL_PORT_WIDTH, only the last PARALLEL_PORT_WIDTH bits received SHALL be kept in dout.
REQ-022 If len < PARALLEL_PORT_WIDTH, dout[W-1:len] SHALL be 0.
REQ-023 ack_in high while dv_out is high SHALL clear dv_out at the next edge; ack_in while dv_out is low SHALL have no effect.
REQ-024 When a frame completes in the same cycle that ack_in is high, dv_out SHALL stay 1 (new word) and overrun SHALL stay 0.
REQ-025 When a frame completes while dv_out = 1 and ack_in = 0, dout SHALL be overwritten, dv_out SHALL stay 1, and overrun SHALL pulse for one cycle.
REQ-026 Back-to-back frames: a start bit sampled in the first IDLE cycle after completion SHALL be accepted.
REQ-027 din is not checked during RECEIVE; every sampled value is taken as data.
REQ-028 busy SHALL be 1 exactly in RECEIVE.

Reset
REQ-029 While rst is high, independent of clk: state = IDLE, counter = 0, shift register = 0, dout = 0, dv_out = 0, busy = 0, overrun = 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no dv_out.
REQ-031 After reset release, the first logic 0 on din SHALL be treated as a start bit.

Verification
REQ-032 Basic frame: bit_length=4; din idle Z, 0, then 1,0,1,1 -> dout=0x000B, dv_out rises the cycle after the last bit, busy high for 4 cycles.
REQ-033 Full width: bit_length=15, data 0x5A5A MSB first -> dout=0x5A5A; bit_length=0 with start bit -> stays IDLE, no dv_out.
REQ-034 Handshake and overrun: two back-to-back 4-bit frames 0xA then 0x3, no ack -> dout=0x3, overrun one-cycle pulse; repeat with ack_in on the completion cycle -> no overrun, dv_out=1.
REQ-035 Mid-frame changes: bit_length changed from 4 to 8 after the start bit -> 4-bit frame received correctly; rst pulse after 2 bits -> all outputs 0, next frame 0x6 received correctly.
REQ-036 Loopback: connect the existing parallel-to-serial transmitter (same parameters, matching bit_length) to din; 100 random words -> each received dout equals the transmitted din, one dv_out per frame.
